// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : PC and 256x24 instruction memory front end; one registered
//               instruction per cycle, load replay, branch redirect.
//               Optional macro IF_JMP_FOLD_EN folds unconditional jumps in fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [INS_W-1:0]  imem_wdata,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [4:0] c_OP_LD  = 5'b10100;
`ifdef IF_JMP_FOLD_EN
  localparam logic [4:0] c_OP_JMP = 5'b11000;
`endif

  logic [INS_W-1:0]  r_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] r_pc;
  logic [INS_W-1:0]  r_ins;
  logic [ADDR_W-1:0] r_ins_pc;
  logic              r_ins_valid;
  logic              r_replay;

  logic [INS_W-1:0]  w_fetch;
  logic              w_load_replay;

  always_ff @(posedge clk) begin
    if (imem_we) begin
      r_mem[imem_waddr] <= imem_wdata;
    end
  end

  // Asynchronous read: a same-edge write to r_pc is seen only next cycle.
  assign w_fetch       = r_mem[r_pc];
  assign w_load_replay = (r_ins[INS_W-1 -: 5] == c_OP_LD) && !r_replay;

`ifdef IF_JMP_FOLD_EN
  logic              w_fetch_is_jmp;
  logic [ADDR_W-1:0] w_jmp_target;
  assign w_fetch_is_jmp = (w_fetch[INS_W-1 -: 5] == c_OP_JMP);
  assign w_jmp_target   = w_fetch[INS_W-6 -: ADDR_W];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      r_ins       <= '0;
      r_ins_pc    <= '0;
      r_ins_valid <= 1'b0;
      r_replay    <= 1'b0;
    end else if (branch_taken) begin
      r_pc        <= branch_target;
      r_ins       <= '0;
      r_ins_valid <= 1'b0;
      r_replay    <= 1'b0;
    end else if (!stall) begin
      r_ins       <= w_fetch;
      r_ins_pc    <= r_pc;
      r_ins_valid <= 1'b1;
      // Load replay holds the PC so the same word is presented twice.
      if (w_load_replay) begin
        r_replay <= 1'b1;
      end
`ifdef IF_JMP_FOLD_EN
      else if (w_fetch_is_jmp) begin
        r_pc     <= w_jmp_target;
        r_replay <= 1'b0;
      end
`endif
      else begin
        r_pc     <= r_pc + ADDR_W'(1);
        r_replay <= 1'b0;
      end
    end
  end

  assign ins       = r_ins;
  assign ins_pc    = r_ins_pc;
  assign ins_valid = r_ins_valid;
  assign pc        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = 8'h00;
  logic [23:0] imem_wdata = 24'h0;
  logic [23:0] ins;
  logic [7:0]  ins_pc;
  logic        ins_valid;
  logic [7:0]  pc;

  int checks = 0;
  int failures = 0;

  instruction_fetch_stage #(.ADDR_W(8), .INS_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .ins_valid    (ins_valid),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
  endtask

  initial begin
    #1;
    // Clear memory under reset, then load the sequential program
    for (int i = 0; i < 256; i++) wr(8'(i), 24'h0);
    wr(8'h00, 24'h000001);
    wr(8'h01, 24'h000002);
    wr(8'h02, 24'h000003);
    wr(8'h03, 24'h000004);
    tick();
    check("rst_ins", 32'(ins), 32'h0);
    check("rst_valid", 32'(ins_valid), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);

    // Sequential fetch
    reset = 1'b0;
    tick();
    check("seq0_ins", 32'(ins), 32'h000001);
    check("seq0_pc", 32'(ins_pc), 32'h00);
    check("seq0_valid", 32'(ins_valid), 32'h1);
    tick();
    check("seq1_ins", 32'(ins), 32'h000002);
    check("seq1_pc", 32'(ins_pc), 32'h01);
    tick();
    check("seq2_ins", 32'(ins), 32'h000003);
    check("seq2_pc", 32'(ins_pc), 32'h02);

    // Stall holds everything
    stall = 1'b1;
    tick();
    check("stall_ins", 32'(ins), 32'h000003);
    check("stall_pc", 32'(pc), 32'h03);
    stall = 1'b0;

    // Jump
    reset = 1'b1;
    wr(8'h02, 24'hC20000);
    wr(8'h40, 24'h123456);
    reset = 1'b0;
    tick();
    check("jmp0_ins", 32'(ins), 32'h000001);
    tick();
    check("jmp1_ins", 32'(ins), 32'h000002);
    tick();
    check("jmp2_ins", 32'(ins), 32'hC20000);
    check("jmp2_inspc", 32'(ins_pc), 32'h02);
`ifdef IF_JMP_FOLD_EN
    check("jmp2_pc", 32'(pc), 32'h40);
    tick();
    check("jmp3_ins", 32'(ins), 32'h123456);
    check("jmp3_inspc", 32'(ins_pc), 32'h40);
`else
    check("jmp2_pc", 32'(pc), 32'h03);
    tick();
    check("jmp3_ins", 32'(ins), 32'h000004);
    check("jmp3_inspc", 32'(ins_pc), 32'h03);
`endif

    // Load replay
    reset = 1'b1;
    wr(8'h01, 24'hA00000);
    wr(8'h02, 24'h0ABCDE);
    wr(8'h10, 24'h0BEEF0);
    reset = 1'b0;
    tick();
    check("ld0_ins", 32'(ins), 32'h000001);
    tick();
    check("ld1_ins", 32'(ins), 32'hA00000);
    tick();
    check("ld2_ins", 32'(ins), 32'h0ABCDE);
    check("ld2_pc", 32'(pc), 32'h02);
    tick();
    check("ld3_ins", 32'(ins), 32'h0ABCDE);
    check("ld3_inspc", 32'(ins_pc), 32'h02);
    check("ld3_pc", 32'(pc), 32'h03);
    tick();
    check("ld4_ins", 32'(ins), 32'h000004);
    check("ld4_inspc", 32'(ins_pc), 32'h03);

    // Reset while replay is set
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("rr_pre_ins", 32'(ins), 32'h0ABCDE);
    reset = 1'b1;
    tick();
    check("rr_ins", 32'(ins), 32'h0);
    check("rr_inspc", 32'(ins_pc), 32'h0);
    check("rr_valid", 32'(ins_valid), 32'h0);
    check("rr_pc", 32'(pc), 32'h0);
    reset = 1'b0;
    tick();
    check("rr0_ins", 32'(ins), 32'h000001);
    tick();
    check("rr1_ins", 32'(ins), 32'hA00000);
    check("rr1_inspc", 32'(ins_pc), 32'h01);

    // Branch overrides stall and pending load replay
    branch_taken  = 1'b1;
    branch_target = 8'h10;
    stall         = 1'b1;
    tick();
    check("br_ins", 32'(ins), 32'h0);
    check("br_valid", 32'(ins_valid), 32'h0);
    check("br_pc", 32'(pc), 32'h10);
    branch_taken = 1'b0;
    stall        = 1'b0;
    tick();
    check("br1_ins", 32'(ins), 32'h0BEEF0);
    check("br1_inspc", 32'(ins_pc), 32'h10);
    check("br1_valid", 32'(ins_valid), 32'h1);

    // PC wrap
    branch_taken  = 1'b1;
    branch_target = 8'hFE;
    tick();
    branch_taken = 1'b0;
    tick();
    check("wrap0", 32'(ins_pc), 32'hFE);
    tick();
    check("wrap1", 32'(ins_pc), 32'hFF);
    check("wrap1_pc", 32'(pc), 32'h00);
    tick();
    check("wrap2", 32'(ins_pc), 32'h00);
    check("wrap2_ins", 32'(ins), 32'h000001);
    tick();
    check("wrap3", 32'(ins_pc), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Pipeline front end for the 8-bit MIPS core. It holds the program counter and an internal 256 x 24-bit instruction memory, and presents one registered 24-bit instruction word per cycle on `ins`; `ins` feeds the dependency-check/decode stage directly. It folds unconditional jumps, replays the instruction after a load so the decode stage's one-cycle load squash loses nothing, and redirects on conditional-branch resolution from execute.

## Interface
- `ADDR_W`, 8: PC / instruction-memory address width.
- `INS_W`, 24: instruction width; opcode in `[23:19]`, jump target in `[18:11]`.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `stall` input 1: external hold; freezes `pc`, `ins`, `ins_pc`, `ins_valid`.
- `branch_taken` input 1: conditional jump resolved taken by execute.
- `branch_target` input ADDR_W: redirect address, valid with `branch_taken`.
- `imem_we` input 1: instruction-memory write enable (boot/test load).
- `imem_waddr` input ADDR_W: write address.
- `imem_wdata` input INS_W: write data.
- `ins` output INS_W: registered instruction to decode; `24'h000000` = NOP.
- `ins_pc` output ADDR_W: address `ins` was fetched from.
- `ins_valid` output 1: `ins` holds a fetched word (0 for reset or flush bubbles).
- `pc` output ADDR_W: current fetch address.

## Operation
- Memory: asynchronous read `F = mem[pc]`; synchronous write on `imem_we`. Same-cycle write/read of one address returns old data. No reset of memory contents.
- Opcode decode:
  - JMP = `11000`.
  - COND = `111xx`.
  - LD = `10100`, tested on the current `ins[23:19]`.
  - JMP is tested on `F[23:19]`.
- Internal flag `replay` (1 bit) records that the current hold is a load replay.
- Per-edge priority, highest first:
  1. `reset`: `pc`=0, `ins`=0, `ins_pc`=0, `ins_valid`=0, `replay`=0.
  2. `branch_taken`: `pc`=`branch_target`, `ins`=0, `ins_valid`=0, `replay`=0. This overrides `stall`.
  3. `stall`: all registers hold.
  4. Load replay (`ins[23:19]`==LD and `replay`==0): `ins`=F, `ins_pc`=`pc`, `ins_valid`=1, `pc` holds, `replay`=1. The same F is presented again next cycle. JMP folding is suppressed on this edge.
  5. Jump fold (F is JMP, macro enabled): `ins`=F, `ins_pc`=`pc`, `pc`=`F[18:11]`, `replay`=0.
  6. Normal: `ins`=F, `ins_pc`=`pc`, `ins_valid`=1, `pc`=`pc`+1, `replay`=0.
- COND words are fetched as normal (predict not-taken). Squashing wrong-path words already downstream is the consumer's job; fetch flushes only `ins`.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 wraps to 8'h00.
- Back-to-back LD: the replayed copy of a following LD does not retrigger, because `replay`=1 on that edge. The next fresh LD does retrigger.

## Timing
- Fetch latency is 1 cycle: the word at `pc` in cycle n appears on `ins` in cycle n+1.
- Folded JMP costs 0 bubbles: the target word follows the JMP directly.
- A taken branch costs 1 bubble: `ins`=0 in the cycle after `branch_taken`, then `mem[branch_target]`.
- A load costs 1 replay cycle: the word after LD appears on `ins` twice in consecutive cycles.
- Reset mid-replay or mid-stall clears `replay`. The first post-reset `ins` is `mem[0]`, one cycle after reset deasserts.

## Configuration
- `IF_JMP_FOLD_EN` defined: unconditional jumps redirect in fetch as in step 5.
- `IF_JMP_FOLD_EN` undefined: step 5 is removed. JMP is fetched like any word with `pc`+1; downstream must assert `branch_taken`/`branch_target` for JMP, which costs 1 bubble.

## Test plan
- Sequential fetch: mem[0..3]=24'h000001..24'h000004, reset 1 cycle. Then `ins` = 000001, 000002, 000003 with `ins_pc` = 0, 1, 2. During reset: `ins`=0, `ins_valid`=0, `pc`=0.
- JMP fold (macro on): mem[2]=24'hC20000 (target 8'h40), mem[8'h40]=24'h123456. Then `ins` = mem0, mem1, C20000, 123456 with `ins_pc`=8'h40. With macro off: mem3 follows C20000.
- Load replay: mem[1]=24'hA00000, mem[2]=24'h0ABCDE. Then `ins` = mem0, A00000, 0ABCDE, 0ABCDE, mem3, with `pc` holding at 2 for one cycle.
- Branch redirect: assert `branch_taken`, `branch_target`=8'h10 together with `stall`=1. Next cycle `ins`=0, `ins_valid`=0, `pc`=8'h10. Following cycle (stall low) `ins`=mem[8'h10].
- Wrap: force `pc` to 8'hFE via branch. Then `ins_pc` = FE, FF, 00, 01.
- Reset during replay: assert reset in the cycle `replay`=1. Then all outputs are 0, and after release `ins`=mem0 once, not duplicated.
